// File: rtl/sin_lut_pkg.sv
// sin_lut_pkg: shared widths, phase field positions and quadrant mirror mapping
package sin_lut_pkg;
  localparam int PHASE_W = 11;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int OUT_W = 17;
  localparam int QUAD_LSB = 9;
  localparam int QUAD_MSB = 10;
  function automatic logic [ADDR_W-1:0] quad_addr(input logic [PHASE_W-1:0] phase);
    return phase[QUAD_LSB] ? ~phase[ADDR_W-1:0] : phase[ADDR_W-1:0];
  endfunction
endpackage

// File: rtl/sin_lut_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, pointer moves to the last winner
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);
  logic [ID_W-1:0] last;
  logic found;
  int k;
  always_comb begin
    grant = '0;
    grant_id = '0;
    found = 1'b0;
    k = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last) + i) % NUM_REQ;
      if (en && !found && req[k]) begin
        grant[k] = 1'b1;
        grant_id = ID_W'(k);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) last <= ID_W'(NUM_REQ - 1);
    else if (|grant) last <= grant_id;
endmodule

// File: rtl/sin_lut_arbiter.sv
// sin_lut_arbiter: shares one quarter-wave sine ROM port among NUM_REQ phase requesters
module sin_lut_arbiter
  import sin_lut_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*PHASE_W-1:0] req_phase,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ADDR_W-1:0]          lut_addr,
  input  logic [DATA_W-1:0]          lut_dout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [OUT_W-1:0]           rsp_data
);
  logic adv, xfer, s1_v, s1_neg, s2_v, s2_neg;
  logic [ID_W-1:0] gnt_id, s1_id, s2_id;
  logic [ADDR_W-1:0] s1_addr, s2_addr;
  logic [PHASE_W-1:0] phase;
  logic [OUT_W-1:0] mag;
  assign adv = !rsp_valid || rsp_ready;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .en(adv && !rst),
    .grant(req_ready),
    .grant_id(gnt_id)
  );
  assign xfer = |(req_valid & req_ready);
  assign phase = req_phase[int'(gnt_id)*PHASE_W +: PHASE_W];
  // on a stall the ROM re-reads S2's address so its data is still there on release
  assign lut_addr = adv ? s1_addr : s2_addr;
  assign mag = {1'b0, lut_dout};
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_addr <= '0;
      s1_id <= '0;
      s1_neg <= 1'b0;
      s2_v <= 1'b0;
      s2_addr <= '0;
      s2_id <= '0;
      s2_neg <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
    end else if (adv) begin
      s1_v <= xfer;
      if (xfer) begin
        s1_addr <= quad_addr(phase);
        s1_id <= gnt_id;
        s1_neg <= phase[QUAD_MSB];
      end
      s2_v <= s1_v;
      s2_addr <= s1_addr;
      s2_id <= s1_id;
      s2_neg <= s1_neg;
      rsp_valid <= s2_v;
      if (s2_v) begin
        rsp_id <= s2_id;
        rsp_data <= s2_neg ? -mag : mag;
      end
    end
  end
endmodule

// File: tb/tb_sin_lut_arbiter.sv
// tb_sin_lut_arbiter: directed checks of arbitration, mirroring, sign, stall and reset
module tb_sin_lut_arbiter;
  logic clk, rst, rsp_ready, rsp_valid;
  logic [3:0] req_valid, req_ready;
  logic [43:0] req_phase;
  logic [8:0] lut_addr;
  logic [15:0] lut_dout;
  logic [1:0] rsp_id;
  logic [16:0] rsp_data;
  int total = 0, bad = 0;
  int g_id [8];
  logic [10:0] g_ph [8];
  int e_addr [8];
  logic [16:0] e_data [8];

  sin_lut_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_phase(req_phase),
    .req_ready(req_ready), .lut_addr(lut_addr), .lut_dout(lut_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM stand-in: LUT[0]=0, LUT[a]=127a+3, one-edge read latency
  function automatic logic [15:0] rom(input logic [8:0] a);
    return a == 0 ? 16'd0 : 16'(int'(a) * 127 + 3);
  endfunction
  always @(posedge clk) lut_dout <= rom(lut_addr);

  function automatic logic [16:0] neg(input int m);
    return 17'(-m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ph(input int id, input logic [10:0] ph);
    req_phase[11*id +: 11] = ph;
  endtask

  // grant k at edge k, its address shows after edge k, its response after edge k+2
  task automatic burst(input int n, input bit all_valid);
    for (int k = 0; k <= n + 3; k++) begin
      if (k < n) begin
        req_valid = all_valid ? 4'hF : 4'(1 << g_id[k]);
        if (!all_valid) set_ph(g_id[k], g_ph[k]);
      end else req_valid = 4'h0;
      @(negedge clk);
      chk("grant", req_ready, k < n ? 32'(1 << g_id[k]) : 0);
      if (k >= 1 && k <= n) chk("addr", lut_addr, e_addr[k-1]);
      chk("rvalid", rsp_valid, k >= 3 && k <= n + 2);
      if (k >= 3 && k <= n + 2) begin
        chk("rid", rsp_id, g_id[k-3]);
        chk("rdata", rsp_data, e_data[k-3]);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    req_phase = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_addr", lut_addr, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    tick();
    rst = 1'b0;
    req_valid = 4'h0;
    tick();
    // single request from requester 2
    g_id[0] = 2; g_ph[0] = 11'h005; e_addr[0] = 5; e_data[0] = 17'd638;
    burst(1, 1'b0);
    // mirror and sign from requester 3
    g_id[0] = 3; g_ph[0] = 11'h205; e_addr[0] = 506; e_data[0] = 17'd64265;
    g_id[1] = 3; g_ph[1] = 11'h405; e_addr[1] = 5; e_data[1] = neg(638);
    g_id[2] = 3; g_ph[2] = 11'h7FF; e_addr[2] = 0; e_data[2] = 17'd0;
    burst(3, 1'b0);
    // round robin with all four requesters valid
    set_ph(0, 11'h010); set_ph(1, 11'h230); set_ph(2, 11'h450); set_ph(3, 11'h670);
    for (int k = 0; k < 6; k++) begin
      g_id[k] = k % 4;
      e_addr[k] = (k % 4 == 0) ? 16 : (k % 4 == 1) ? 463 : (k % 4 == 2) ? 80 : 399;
      e_data[k] = (k % 4 == 0) ? 17'd2035 : (k % 4 == 1) ? 17'd58804 : (k % 4 == 2) ? neg(10163) : neg(50676);
    end
    burst(6, 1'b1);
    // backpressure: three grants to requester 0, then a 4-cycle stall
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0001;
      set_ph(0, k == 0 ? 11'h001 : k == 1 ? 11'h202 : 11'h603);
      @(negedge clk);
      chk("bp_grant", req_ready, 4'b0001);
      tick();
    end
    set_ph(1, 11'h0FF);
    for (int s = 3; s <= 6; s++) begin
      rsp_ready = 1'b0;
      req_valid = (s == 4 || s == 5) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      chk("stall_ready", req_ready, 0);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 17'd130);
      chk("stall_id", rsp_id, 0);
      chk("stall_addr", lut_addr, 509);
      tick();
    end
    rsp_ready = 1'b1;
    for (int s = 7; s <= 10; s++) begin
      @(negedge clk);
      chk("rel_ready", req_ready, 0);
      chk("rel_valid", rsp_valid, s <= 9);
      if (s <= 9) begin
        chk("rel_id", rsp_id, 0);
        chk("rel_data", rsp_data, s == 7 ? 17'd130 : s == 8 ? 17'd64646 : neg(64519));
      end
      tick();
    end
    // dropped request must not have moved the pointer: requester 1 beats 2
    req_valid = 4'b0110;
    @(negedge clk);
    chk("ptr_hold", req_ready, 4'b0010);
    tick();
    req_valid = 4'h0;
    tick();
    @(negedge clk);
    chk("ptr_v0", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("ptr_v1", rsp_valid, 1);
    chk("ptr_id", rsp_id, 1);
    chk("ptr_data", rsp_data, 17'd32388);
    tick();
    // reset with two requests in flight
    set_ph(2, 11'h010); set_ph(3, 11'h020);
    req_valid = 4'b1100;
    @(negedge clk);
    chk("mr_g0", req_ready, 4'b0100);
    tick();
    @(negedge clk);
    chk("mr_g1", req_ready, 4'b1000);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    req_valid = 4'h0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("mr_quiet", rsp_valid, 0);
      if (s == 0) chk("mr_addr", lut_addr, 0);
      tick();
    end
    set_ph(0, 11'h100);
    req_valid = 4'hF;
    @(negedge clk);
    chk("mr_first", req_ready, 4'b0001);
    tick();
    req_valid = 4'h0;
    tick();
    @(negedge clk);
    chk("mr_v0", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("mr_v1", rsp_valid, 1);
    chk("mr_id", rsp_id, 0);
    chk("mr_data", rsp_data, 17'd32515);
    tick();
    @(negedge clk);
    chk("mr_end", rsp_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
